mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-ported request RAM between the instruction-fetch port (pc) and the
//  data port (ALU address, load/store) of the single-cycle core. Sequences one RAM access
//  at a time, round-robin between ports, with a busy-based handshake and a watchdog abort.
//  Sits between the core (pc/control/writeToReg) and request_ram, in place of the request unit.
// PARAMETERS
//  ADDR_W   32   address width, all ports
//  DATA_W   32   data width, all ports
//  TIMEOUT  255  max cycles a RAM access may stall (ram_busy=1) before abort; >=1
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  i_req      in   1       fetch request; level, held until i_ready
//  i_addr     in   ADDR_W  fetch address (pc)
//  i_rdata    out  DATA_W  fetched instruction; valid while i_ready=1
//  i_ready    out  1       one-cycle fetch-complete pulse
//  d_ren      in   1       data read request; level, held until d_ready
//  d_wen      in   1       data write request; level, held until d_ready
//  d_addr     in   ADDR_W  data address (ALU result)
//  d_wdata    in   DATA_W  store data (rs2)
//  d_rdata    out  DATA_W  load data; valid while d_ready=1
//  d_ready    out  1       one-cycle data-complete pulse
//  ram_addr   out  ADDR_W  RAM address, held stable for the whole access
//  ram_wdata  out  DATA_W  RAM write data
//  ram_ren    out  1       RAM read strobe, held until completion
//  ram_wen    out  1       RAM write strobe, held until completion
//  ram_rdata  in   DATA_W  RAM read data, valid in completion cycle
//  ram_busy   in   1       RAM stall; completion = strobe high and ram_busy=0 in same cycle
//  err        out  1       one-cycle pulse: timeout abort or d_ren&d_wen conflict
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=DATA (fetch wins first tie), all outputs 0, addr/data regs 0.
//  States: IDLE, I_ACC, D_ACC, RESP. Strobes and ram_addr are Moore (from state + latched regs).
//  IDLE: requests sampled only here. None -> stay. One pending -> grant it. Both pending ->
//   grant the port != last_grant. Grant latches addr (and wdata, op); next state I_ACC/D_ACC.
//  I_ACC: ram_ren=1, ram_addr=latched i_addr. D_ACC: ram_ren or ram_wen per latched op.
//   d_ren&d_wen both high at grant -> treated as write, err pulses in RESP.
//  Completion (ram_busy=0 in ACC): capture ram_rdata (reads only), -> RESP.
//  RESP: ready of granted port =1 for exactly this cycle, rdata held; last_grant updated;
//   -> IDLE. Requester drops its request by the next edge; no port is granted in RESP.
//  Latency: request seen in IDLE at cycle t -> strobe at t+1 -> ready at t+2 minimum;
//   +1 cycle per ram_busy stall cycle. Back-to-back: new grant at earliest t+3.
//  Input changes on addr/wdata during ACC/RESP are ignored (latched at grant).
//  Watchdog: counts consecutive ACC cycles with ram_busy=1; at count==TIMEOUT, drop strobe,
//   -> RESP with rdata=0, ready and err both pulsed. Counter clears on every grant.
//  Writes: d_rdata = 0 in RESP. i_rdata/d_rdata keep last value outside RESP.
//  Reset mid-access: synchronous return to IDLE next edge, strobes deassert, no ready pulse.
//  Request deasserted mid-access: access still completes and ready still pulses.
// STRUCTURE
//  Package mem_arb_pkg: typedef enum {IDLE,I_ACC,D_ACC,RESP} arb_state_t;
//   typedef enum logic {GRANT_I,GRANT_D} grant_t; op encoding constants.
//  Sub-module mem_arb_watchdog (param TIMEOUT; in clk,rst,clear,stall; out expired):
//   saturating counter, $clog2(TIMEOUT+1) bits.
// TESTING
//  1 Fetch only, ram_busy=0, i_addr=0x0000_0010, ram_rdata=0x0050_0093 -> ram_ren at t+1,
//    i_ready & i_rdata=0x0050_0093 at t+2, exactly one pulse.
//  2 i_req & d_ren same cycle after reset -> fetch granted first, then data; next tie
//    after data -> fetch again (alternation verified over 4 ties).
//  3 Store d_addr=0x40, d_wdata=0xDEAD_BEEF, ram_busy=1 for 3 cycles -> ram_wen held 4
//    cycles, addr/wdata stable despite input changes, d_ready at t+5, d_rdata=0.
//  4 ram_busy stuck 1, TIMEOUT=4 -> strobe drops after 4 stall cycles, ready+err pulse,
//    rdata=0, next request serviced normally.
//  5 rst asserted during D_ACC -> next cycle IDLE, strobes 0, no d_ready; re-request works.
//  6 d_ren&d_wen both 1 -> RAM write performed, err and d_ready pulse together.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and op encodings for the memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    I_ACC,
    D_ACC,
    RESP
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - core-side and RAM-side signal bundle of the memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  // fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  // data port
  logic              d_ren;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  // RAM side
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ren;
  logic              ram_wen;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_busy;
  logic              err;

  // core + RAM environment drives requests and RAM responses
  modport master (
    output i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata, ram_busy,
    input  i_rdata, i_ready, d_rdata, d_ready, ram_addr, ram_wdata, ram_ren, ram_wen, err
  );

  // the arbiter itself
  modport slave (
    input  i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata, ram_busy,
    output i_rdata, i_ready, d_rdata, d_ready, ram_addr, ram_wdata, ram_ren, ram_wen, err
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - saturating count of consecutive RAM stall cycles
module mem_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;

  // expiry is flagged in the stall cycle that brings the count to TIMEOUT,
  // so the strobe is held for exactly TIMEOUT stalled cycles
  assign w_cnt_inc = (r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;
  assign expired   = stall && (w_cnt_inc == CW'(TIMEOUT));

  // count consecutive stalls; any non-stall cycle or new grant restarts the count
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (stall) begin
      r_cnt <= w_cnt_inc;
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter in front of a single-ported RAM
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  arb_state_t        r_state;
  grant_t            r_last_grant;
  grant_t            r_grant;
  logic              r_op;
  logic              r_conflict;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_ram_ren;
  logic              r_ram_wen;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_ready;
  logic              r_d_ready;
  logic              r_err;

  logic w_d_pend;
  logic w_idle;
  logic w_grant_i;
  logic w_grant_d;
  logic w_in_acc;
  logic w_stall;
  logic w_expired;

  // requests only count while idle; on a tie the port not served last wins
  assign w_d_pend  = bus.d_ren | bus.d_wen;
  assign w_idle    = (r_state == IDLE);
  assign w_grant_i = w_idle && bus.i_req && (!w_d_pend || (r_last_grant == GRANT_D));
  assign w_grant_d = w_idle && w_d_pend && !w_grant_i;
  assign w_in_acc  = (r_state == I_ACC) || (r_state == D_ACC);
  assign w_stall   = w_in_acc && bus.ram_busy;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_grant_i | w_grant_d),
    .stall   (w_stall),
    .expired (w_expired)
  );

  // arbitration FSM; strobes, address and responses are all registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_D;
      r_grant      <= GRANT_I;
      r_op         <= OP_READ;
      r_conflict   <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_ram_ren    <= 1'b0;
      r_ram_wen    <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_i_ready    <= 1'b0;
      r_d_ready    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_grant    <= GRANT_I;
            r_op       <= OP_READ;
            r_conflict <= 1'b0;
            r_ram_addr <= bus.i_addr;
            r_ram_ren  <= 1'b1;
            r_ram_wen  <= 1'b0;
            r_state    <= I_ACC;
          end else if (w_grant_d) begin
            // a simultaneous read+write request is carried out as a write
            r_grant     <= GRANT_D;
            r_op        <= bus.d_wen ? OP_WRITE : OP_READ;
            r_conflict  <= bus.d_ren & bus.d_wen;
            r_ram_addr  <= bus.d_addr;
            r_ram_wdata <= bus.d_wdata;
            r_ram_ren   <= ~bus.d_wen;
            r_ram_wen   <= bus.d_wen;
            r_state     <= D_ACC;
          end
        end
        I_ACC, D_ACC: begin
          if (!bus.ram_busy) begin
            r_ram_ren <= 1'b0;
            r_ram_wen <= 1'b0;
            r_state   <= RESP;
            if (r_state == I_ACC) begin
              r_i_rdata <= bus.ram_rdata;
              r_i_ready <= 1'b1;
            end else begin
              r_d_rdata <= (r_op == OP_READ) ? bus.ram_rdata : '0;
              r_d_ready <= 1'b1;
              r_err     <= r_conflict;
            end
          end else if (w_expired) begin
            // abort: the requester still gets its ready, with zero data and err
            r_ram_ren <= 1'b0;
            r_ram_wen <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= RESP;
            if (r_state == I_ACC) begin
              r_i_rdata <= '0;
              r_i_ready <= 1'b1;
            end else begin
              r_d_rdata <= '0;
              r_d_ready <= 1'b1;
            end
          end
        end
        RESP: begin
          r_last_grant <= r_grant;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.ram_ren   = r_ram_ren;
  assign bus.ram_wen   = r_ram_wen;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.i_ready   = r_i_ready;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_ready   = r_d_ready;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_d;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          busy;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic quiet_inputs();
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_ren     = 1'b0;
    bus.d_wen     = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.ram_rdata = '0;
    bus.ram_busy  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    quiet_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // one isolated transaction from an idle arbiter, checked cycle by cycle
  task automatic run_vec(input vec_t v, input int n);
    logic exp_w;
    logic busy;
    int   k;
    bit   done;
    exp_w = v.is_d & v.wen;
    @(negedge clk);
    bus.i_req    = ~v.is_d;
    bus.d_ren    = v.is_d & v.ren;
    bus.d_wen    = v.is_d & v.wen;
    bus.i_addr   = v.is_d ? 32'h0 : v.addr;
    bus.d_addr   = v.is_d ? v.addr : 32'h0;
    bus.d_wdata  = v.wdata;
    bus.ram_busy = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_ren", n), {31'b0, bus.ram_ren}, {31'b0, ~exp_w});
    chk($sformatf("v%0d_wen", n), {31'b0, bus.ram_wen}, {31'b0, exp_w});
    chk($sformatf("v%0d_addr", n), bus.ram_addr, v.addr);
    if (exp_w) chk($sformatf("v%0d_wdata", n), bus.ram_wdata, v.wdata);
    k    = 0;
    done = 1'b0;
    while (!done) begin
      busy          = (k < v.busy);
      bus.ram_busy  = busy;
      bus.ram_rdata = busy ? $urandom : v.rdata;
      bus.i_addr    = $urandom;
      bus.d_addr    = $urandom;
      bus.d_wdata   = $urandom;
      if (!busy || (k + 1 == TO)) begin
        done = 1'b1;
      end else begin
        @(negedge clk);
        k++;
        chk($sformatf("v%0d_hold_strobe", n), {30'b0, bus.ram_ren, bus.ram_wen}, {30'b0, ~exp_w, exp_w});
        chk($sformatf("v%0d_hold_addr", n), bus.ram_addr, v.addr);
        if (exp_w) chk($sformatf("v%0d_hold_wdata", n), bus.ram_wdata, v.wdata);
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d_ready", n), {30'b0, bus.i_ready, bus.d_ready}, {30'b0, ~v.is_d, v.is_d});
    chk($sformatf("v%0d_err", n), {31'b0, bus.err}, {31'b0, v.exp_err});
    chk($sformatf("v%0d_strobe_off", n), {30'b0, bus.ram_ren, bus.ram_wen}, 32'h0);
    chk($sformatf("v%0d_rdata", n), v.is_d ? bus.d_rdata : bus.i_rdata, v.exp_rdata);
    quiet_inputs();
    @(negedge clk);
    chk($sformatf("v%0d_one_pulse", n), {29'b0, bus.i_ready, bus.d_ready, bus.err}, 32'h0);
    chk($sformatf("v%0d_rdata_held", n), v.is_d ? bus.d_rdata : bus.i_rdata, v.exp_rdata);
  endtask

  // transaction-level reference for random traffic
  logic [31:0] mem [16];

  task automatic random_phase(input int cycles);
    bit          acc_on, acc_d, acc_w, acc_conf;
    logic [31:0] acc_addr, acc_wdata;
    int          stall;
    bit          resp_due, resp_d, resp_err;
    logic [31:0] resp_rdata;
    bit          last_d;
    bit          prev_idle, prev_ireq, prev_dren, prev_dwen;
    logic [31:0] prev_iaddr, prev_daddr, prev_dwdata;
    bit          this_resp, drop_i, drop_d, busy;
    int          r;
    logic [3:0]  idx;
    acc_on = 0; resp_due = 0; last_d = 1; stall = 0;
    prev_idle = 1; prev_ireq = 0; prev_dren = 0; prev_dwen = 0;
    prev_iaddr = 0; prev_daddr = 0; prev_dwdata = 0;
    acc_d = 0; acc_w = 0; acc_conf = 0; acc_addr = 0; acc_wdata = 0;
    resp_d = 0; resp_err = 0; resp_rdata = 0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      this_resp = 0; drop_i = 0; drop_d = 0;
      if (resp_due) begin
        this_resp = 1;
        chk("rnd_ready", {30'b0, bus.i_ready, bus.d_ready}, {30'b0, ~resp_d, resp_d});
        chk("rnd_err", {31'b0, bus.err}, {31'b0, resp_err});
        chk("rnd_rdata", resp_d ? bus.d_rdata : bus.i_rdata, resp_rdata);
        chk("rnd_resp_strobe", {30'b0, bus.ram_ren, bus.ram_wen}, 32'h0);
        if (resp_d) begin
          bus.d_ren = 0; bus.d_wen = 0; drop_d = 1;
        end else begin
          bus.i_req = 0; drop_i = 1;
        end
        last_d   = resp_d;
        resp_due = 0;
      end else begin
        chk("rnd_no_pulse", {29'b0, bus.i_ready, bus.d_ready, bus.err}, 32'h0);
        if (!acc_on && prev_idle && (prev_ireq || prev_dren || prev_dwen)) begin
          acc_d     = (prev_dren | prev_dwen) && (!prev_ireq || !last_d);
          acc_w     = acc_d && prev_dwen;
          acc_conf  = acc_d && prev_dren && prev_dwen;
          acc_addr  = acc_d ? prev_daddr : prev_iaddr;
          acc_wdata = prev_dwdata;
          acc_on    = 1;
          stall     = 0;
        end
        if (acc_on) begin
          chk("rnd_strobe", {30'b0, bus.ram_ren, bus.ram_wen}, {30'b0, ~acc_w, acc_w});
          chk("rnd_addr", bus.ram_addr, acc_addr);
          if (acc_w) chk("rnd_wdata", bus.ram_wdata, acc_wdata);
        end else begin
          chk("rnd_idle_strobe", {30'b0, bus.ram_ren, bus.ram_wen}, 32'h0);
        end
      end
      prev_idle = !this_resp && !acc_on;
      // RAM behaviour for this cycle
      bus.ram_rdata = mem[bus.ram_addr[5:2]];
      if (acc_on) begin
        busy = ($urandom_range(0, 2) == 0);
        idx  = acc_addr[5:2];
        if (!busy) begin
          resp_due = 1; resp_d = acc_d; resp_err = acc_conf;
          if (acc_w) begin
            mem[idx]   = acc_wdata;
            resp_rdata = 0;
          end else begin
            resp_rdata = mem[idx];
          end
          acc_on = 0;
        end else begin
          stall++;
          if (stall == TO) begin
            resp_due = 1; resp_d = acc_d; resp_err = 1; resp_rdata = 0;
            acc_on = 0;
          end
        end
      end else begin
        busy = $urandom_range(0, 1) != 0;
      end
      bus.ram_busy = busy;
      // requesters; addresses and store data wander freely outside the grant cycle
      bus.i_addr  = $urandom & 32'hFFFF_FFFC;
      bus.d_addr  = $urandom & 32'hFFFF_FFFC;
      bus.d_wdata = $urandom;
      if (!bus.i_req && !drop_i && $urandom_range(0, 2) == 0) bus.i_req = 1;
      if (!bus.d_ren && !bus.d_wen && !drop_d && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 7);
        bus.d_ren = (r == 0) || (r > 3);
        bus.d_wen = (r <= 3);
      end
      prev_ireq   = bus.i_req;
      prev_dren   = bus.d_ren;
      prev_dwen   = bus.d_wen;
      prev_iaddr  = bus.i_addr;
      prev_daddr  = bus.d_addr;
      prev_dwdata = bus.d_wdata;
    end
    quiet_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0050_0093, 0, 32'h0050_0093, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h1111_1111, 3, 32'h0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'h1234_5678, 1, 32'h1234_5678, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h7777_7777, 99, 32'h0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0048, 32'h0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_004C, 32'h0BAD_F00D, 32'hFFFF_FFFF, 0, 32'h0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0000_0024, 32'h0, 32'hA5A5_A5A5, 2, 32'hA5A5_A5A5, 1'b0};

    rst = 1'b1;
    quiet_inputs();
    do_reset();
    @(negedge clk);
    chk("reset_pulses", {29'b0, bus.i_ready, bus.d_ready, bus.err}, 32'h0);
    chk("reset_strobes", {30'b0, bus.ram_ren, bus.ram_wen}, 32'h0);
    chk("reset_addr", bus.ram_addr, 32'h0);
    chk("reset_wdata", bus.ram_wdata, 32'h0);
    chk("reset_rdata", bus.i_rdata | bus.d_rdata, 32'h0);

    // four ties in a row: fetch first after reset, then strict alternation
    bus.i_req  = 1; bus.i_addr = 32'h100;
    bus.d_ren  = 1; bus.d_addr = 32'h200;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      chk($sformatf("tie%0d_addr", r), bus.ram_addr, (r % 2 == 0) ? 32'h100 : 32'h200);
      chk($sformatf("tie%0d_ren", r), {31'b0, bus.ram_ren}, 32'h1);
      bus.ram_busy  = 0;
      bus.ram_rdata = 32'(r + 1);
      @(negedge clk);
      chk($sformatf("tie%0d_ready", r), {30'b0, bus.i_ready, bus.d_ready},
          (r % 2 == 0) ? 32'h2 : 32'h1);
      chk($sformatf("tie%0d_rdata", r), (r % 2 == 0) ? bus.i_rdata : bus.d_rdata, 32'(r + 1));
      if (r == 3) begin
        bus.i_req = 0; bus.d_ren = 0;
      end else if (r % 2 == 0) begin
        bus.i_req = 0;
        @(negedge clk);
        bus.i_req = 1;
      end else begin
        bus.d_ren = 0;
        @(negedge clk);
        bus.d_ren = 1;
      end
    end
    @(negedge clk);

    for (int n = 0; n < 7; n++) run_vec(vecs[n], n);

    // reset while a store is stalled in the access state
    @(negedge clk);
    bus.d_wen = 1; bus.d_addr = 32'h80; bus.d_wdata = 32'h0000_0011;
    @(negedge clk);
    chk("rst_mid_wen", {31'b0, bus.ram_wen}, 32'h1);
    bus.ram_busy = 1;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_strobes", {30'b0, bus.ram_ren, bus.ram_wen}, 32'h0);
    chk("rst_mid_no_ready", {30'b0, bus.d_ready, bus.err}, 32'h0);
    rst = 0;
    bus.ram_busy = 0;
    @(negedge clk);
    chk("rst_mid_no_ready2", {31'b0, bus.d_ready}, 32'h0);
    chk("rst_rereq_wen", {31'b0, bus.ram_wen}, 32'h1);
    chk("rst_rereq_addr", bus.ram_addr, 32'h80);
    @(negedge clk);
    chk("rst_rereq_ready", {31'b0, bus.d_ready}, 32'h1);
    quiet_inputs();
    @(negedge clk);

    do_reset();
    random_phase(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
